// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multi-cycle MIPS datapath. Sequences fetch,
//   decode, execute, memory and writeback over several cycles and drives the
//   datapath mux selects, write enables and the 2-bit ALU operation class.
//   A memory-ready handshake stalls FETCH, MEMRD and MEMWR, and a wrapping
//   counter tracks retired instructions.
//
// Handshake: a memory access (FETCH, MEMRD, MEMWR) is in flight while the FSM
//   sits in that state; it completes on the rising edge where mem_ready=1, and
//   the FSM advances on that same edge. mem_ready is ignored in every other
//   state.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   op[5:0]           opcode from the instruction register
//   mem_ready         memory access completes this cycle
//   pcwrite ... pcsource  datapath controls (see port list)
//   illegal_op        one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0]        current state encoding (debug)
//   retired[CNT_W-1:0] completed-instruction count, wraps
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             irwrite,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             aluop1,
    output logic             aluop0,
    output logic [1:0]       pcsource,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Pure Moore controls; registered from the next state so they change
    // together with the state register. irwrite and the FETCH half of
    // pcwrite depend on mem_ready and are combined combinationally below.
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       aluop1;
        logic       aluop0;
        logic [1:0] pcsource;
    } ctrl_t;

    state_t            state_q;
    state_t            state_d;
    ctrl_t             ctrl_q;
    logic [CNT_W-1:0]  retired_q;
    logic              retire_now;

    function automatic logic op_supported(input logic [5:0] o);
        return (o == OP_RTYPE) || (o == OP_LW) || (o == OP_SW) ||
               (o == OP_BEQ) || (o == OP_J) || (o == OP_ADDI);
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
            end
            S_MEMADR, S_ADDI_EX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_RTYPE_EX: begin
                c.alusrca = 1'b1;
                c.aluop1  = 1'b1;
            end
            S_RTYPE_WB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluop0      = 1'b1;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
            end
            S_JUMP: begin
                c.pcwrite  = 1'b1;
                c.pcsource = 2'b10;
            end
            S_ADDI_WB: begin
                c.regwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEMWB, S_RTYPE_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                        state_d = S_FETCH;
            // Unused encodings recover through FETCH.
            default:    state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        retire_now = 1'b0;
        case (state_q)
            S_MEMWB, S_RTYPE_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire_now = 1'b1;
            S_MEMWR: retire_now = mem_ready;
            default: retire_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_ctrl(state_d);
            if (retire_now) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    assign pcwrite     = ctrl_q.pcwrite | ((state_q == S_FETCH) & mem_ready);
    assign irwrite     = (state_q == S_FETCH) & mem_ready;
    assign illegal_op  = (state_q == S_DECODE) & ~op_supported(op);
    assign pcwritecond = ctrl_q.pcwritecond;
    assign iord        = ctrl_q.iord;
    assign memread     = ctrl_q.memread;
    assign memwrite    = ctrl_q.memwrite;
    assign memtoreg    = ctrl_q.memtoreg;
    assign regdst      = ctrl_q.regdst;
    assign regwrite    = ctrl_q.regwrite;
    assign alusrca     = ctrl_q.alusrca;
    assign alusrcb     = ctrl_q.alusrcb;
    assign aluop1      = ctrl_q.aluop1;
    assign aluop0      = ctrl_q.aluop0;
    assign pcsource    = ctrl_q.pcsource;
    assign state       = state_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control (CNT_W=4 so counter wrap is reachable).
// The driver walks each instruction through its expected cycle list and
// pushes one expected observation vector per cycle; the monitor pops and
// compares on every falling edge.
module tb_multicycle_control;

    localparam int CNT_W = 4;
    localparam int W     = 4 + 17 + CNT_W;

    logic             clk;
    logic             rst_n;
    logic [5:0]       op;
    logic             mem_ready;
    logic             pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
    logic             irwrite, regdst, regwrite, alusrca, aluop1, aluop0;
    logic [1:0]       alusrcb, pcsource;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .irwrite(irwrite), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop1(aluop1),
        .aluop0(aluop0), .pcsource(pcsource), .illegal_op(illegal_op),
        .state(state), .retired(retired)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           cnt    = 0;   // model retired count

    logic [5:0] legal_ops [6];
    initial legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b001000};

    function automatic bit is_legal(input logic [5:0] o);
        for (int i = 0; i < 6; i++)
            if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    // Expected observation for a cycle spent in state st.
    function automatic logic [W-1:0] exp_vec(input int st, input bit mr,
                                             input logic [5:0] o, input int c);
        logic pw, pwc, io, mrd, mwr, m2r, irw, rd, rw, asa, a1, a0, ill;
        logic [1:0] asb, pcs;
        {pw, pwc, io, mrd, mwr, m2r, irw, rd, rw, asa, a1, a0, ill} = '0;
        asb = 2'b00;
        pcs = 2'b00;
        case (st)
            1:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            2:  begin asb = 2'b11; ill = !is_legal(o); end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mrd = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; io = 1; end
            7:  begin asa = 1; a1 = 1; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; a0 = 1; pwc = 1; pcs = 2'b01; end
            10: begin pw = 1; pcs = 2'b10; end
            11: begin asa = 1; asb = 2'b10; end
            12: begin rw = 1; end
            default: ;
        endcase
        return {4'(st), pw, pwc, io, mrd, mwr, m2r, irw, rd, rw, asa, asb,
                a1, a0, pcs, ill, CNT_W'(c)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cycle(input int st, input bit mr);
        mem_ready = mr;
        exp_q.push_back(exp_vec(st, mr, op, cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cycle(input int st);
        cycle(st, 1'($urandom_range(0, 1)));
    endtask

    task automatic stall_state(input int st, input int stalls);
        for (int i = 0; i < stalls; i++) cycle(st, 1'b0);
        cycle(st, 1'b1);
    endtask

    task automatic run_instr(input logic [5:0] o, input int fs, input int ms);
        op = o;
        stall_state(1, fs);
        rnd_cycle(2);
        case (o)
            6'b000000: begin rnd_cycle(7); rnd_cycle(8); end
            6'b100011: begin rnd_cycle(3); stall_state(4, ms); rnd_cycle(5); end
            6'b101011: begin rnd_cycle(3); stall_state(6, ms); end
            6'b000100: rnd_cycle(9);
            6'b000010: rnd_cycle(10);
            6'b001000: begin rnd_cycle(11); rnd_cycle(12); end
            default: ;
        endcase
        if (is_legal(o)) cnt = (cnt + 1) % (1 << CNT_W);
    endtask

    // Cycle with reset held low; model state is IDLE with count cleared.
    task automatic reset_cycle();
        rst_n = 1'b0;
        cnt   = 0;
        rnd_cycle(0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, pcwrite, pcwritecond, iord, memread, memwrite,
                 memtoreg, irwrite, regdst, regwrite, alusrca, alusrcb,
                 aluop1, aluop0, pcsource, illegal_op, retired};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle t=%0t exp_state=%0d: actual=%h required=%h",
                         $time, e[W-1 -: 4], a, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] o;
        rst_n     = 1'b0;
        op        = 6'b000000;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_cycle();
        reset_cycle();
        rst_n = 1'b1;
        rnd_cycle(0);

        // R-type, no stalls
        run_instr(6'b000000, 0, 0);
        // lw: 3 fetch stalls, 2 read stalls
        run_instr(6'b100011, 3, 2);
        // beq
        run_instr(6'b000100, 0, 0);
        // illegal opcode
        run_instr(6'b111111, 1, 0);

        // sw aborted by reset while stalled in MEMWR
        op = 6'b101011;
        stall_state(1, 0);
        rnd_cycle(2);
        rnd_cycle(3);
        cycle(6, 1'b0);
        cycle(6, 1'b0);
        mem_ready = 1'b0;
        reset_cycle();   // asserted mid-cycle while DUT sits in MEMWR
        rst_n = 1'b1;
        rnd_cycle(0);

        // 16 jumps from a cleared counter: count wraps back to 0
        for (int i = 0; i < 16; i++) run_instr(6'b000010, 0, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(6'b101011, 2, 3);

        // randomized mix
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0)
                o = 6'($urandom_range(0, 63));
            else
                o = legal_ops[$urandom_range(0, 5)];
            run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // bounded drain of the scoreboard
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
